// File: rtl/cdc_fifo_rptr_empty.sv
// Read-side pointer, empty/almost-empty flags and occupancy level for a dual-clock FIFO.
// The write Gray pointer arrives already synchronized into r_clk; r_ptr goes back to the write domain.
module cdc_fifo_rptr_empty #(
  parameter int ADDR_SIZE          = 4,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                 r_clk,
  input  logic                 r_rst_n,
  input  logic                 r_inc,
  input  logic [ADDR_SIZE:0]   r_q2_wptr,
  output logic                 r_empty,
  output logic                 r_almost_empty,
  output logic [ADDR_SIZE:0]   r_ptr,
  output logic [ADDR_SIZE-1:0] r_addr,
  output logic [ADDR_SIZE:0]   r_level
);

  localparam logic [ADDR_SIZE:0] AE_LEVEL = (ADDR_SIZE+1)'(ALMOST_EMPTY_LEVEL);

  logic [ADDR_SIZE:0] r_bin;
  logic [ADDR_SIZE:0] r_bin_next;
  logic [ADDR_SIZE:0] r_gray_next;
  logic [ADDR_SIZE:0] w_bin_sync;
  logic [ADDR_SIZE:0] level_next;
  logic               rd_fire;

  // Handshake: r_inc is a request; a read is taken on an r_clk edge only when
  // r_empty is 0 at that edge. r_inc while empty is dropped, so no underflow.
  assign rd_fire = r_inc & ~r_empty;

  always_comb begin
    r_bin_next  = r_bin + {{ADDR_SIZE{1'b0}}, rd_fire};
    r_gray_next = (r_bin_next >> 1) ^ r_bin_next;
  end

  // Gray-to-binary: each bit is the XOR of itself and all higher Gray bits.
  always_comb begin
    w_bin_sync            = '0;
    w_bin_sync[ADDR_SIZE] = r_q2_wptr[ADDR_SIZE];
    for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
      w_bin_sync[i] = w_bin_sync[i+1] ^ r_q2_wptr[i];
    end
  end

  // Modulo arithmetic gives 0..2^ADDR_SIZE; the extra lap bit makes full distinct from empty.
  assign level_next = w_bin_sync - r_bin_next;

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_bin          <= '0;
      r_ptr          <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_level        <= '0;
    end else begin
      r_bin          <= r_bin_next;
      r_ptr          <= r_gray_next;
      r_empty        <= (r_gray_next == r_q2_wptr);
      r_almost_empty <= (level_next <= AE_LEVEL);
      r_level        <= level_next;
    end
  end

  assign r_addr = r_bin[ADDR_SIZE-1:0];

endmodule

// File: doc/cdc_fifo_rptr_empty.md
Name: cdc_fifo_rptr_empty

Overview:
Read-side pointer and empty/level logic for the dual-clock FIFO. It is the read-domain counterpart of the write pointer/full block.
- Consumes the write Gray pointer after it has been synchronized into the read domain by the two-flop synchronizer.
- Produces the read Gray pointer that the write domain synchronizes back.
- Provides the binary RAM read address, registered empty and almost-empty flags, and a registered occupancy level.

Parameters:
ADDR_SIZE, 4, RAM address width; depth = 2^ADDR_SIZE; pointers are ADDR_SIZE+1 bits
ALMOST_EMPTY_LEVEL, 1, r_almost_empty asserts when occupancy <= this value; legal range 1..2^ADDR_SIZE-1

Ports:
r_clk  input  1  read-domain clock
r_rst_n  input  1  asynchronous active-low reset
r_inc  input  1  read request; honoured only when r_empty=0
r_q2_wptr  input  ADDR_SIZE+1  write Gray pointer, already synchronized to r_clk
r_empty  output  1  registered empty flag
r_almost_empty  output  1  registered almost-empty flag
r_ptr  output  ADDR_SIZE+1  registered read Gray pointer, sent to the write domain
r_addr  output  ADDR_SIZE  binary RAM read address, r_bin[ADDR_SIZE-1:0]
r_level  output  ADDR_SIZE+1  registered occupancy as seen by the read domain, 0..2^ADDR_SIZE

Behaviour:
- Reset is asynchronous, on the falling edge of r_rst_n. It sets: r_bin=0, r_ptr=0, r_empty=1, r_almost_empty=1, r_level=0. This applies mid-operation too; all outputs take these values immediately, with no clock needed.
- Pointer update:
  - r_bin_next = r_bin + (r_inc & ~r_empty), wrapping modulo 2^(ADDR_SIZE+1).
  - r_gray_next = (r_bin_next >> 1) ^ r_bin_next.
  - Each r_clk edge: r_bin <= r_bin_next; r_ptr <= r_gray_next.
- r_addr is combinational from r_bin; it always addresses the word at the FIFO head. RAM read data for the current head is valid while r_empty=0.
- r_inc while r_empty=1 is ignored: the pointer does not move and there is no underflow.
- Write-pointer decode:
  - w_bin_sync = Gray-to-binary of r_q2_wptr.
  - Bit ADDR_SIZE passes through unchanged. Each lower bit i = XOR of r_q2_wptr[ADDR_SIZE:i].
- Level: level_next = (w_bin_sync - r_bin_next) modulo 2^(ADDR_SIZE+1). r_level <= level_next.
- Flags, registered each r_clk edge:
  - r_empty <= (r_gray_next == r_q2_wptr). This is equivalent to level_next==0, but must be implemented as the Gray compare.
  - r_almost_empty <= (level_next <= ALMOST_EMPTY_LEVEL). It is therefore also 1 whenever empty.
- Latency:
  - Reading the last word sets r_empty=1 on the same edge that advances r_ptr.
  - A new r_q2_wptr value updates r_empty, r_almost_empty and r_level on the next r_clk edge.
  - End to end from the write domain, empty is pessimistic by the 2-flop sync plus this register. This is safe and intentional.
- Simultaneous read and r_q2_wptr change: both are folded into level_next in the same cycle.
- Wrap-around: the pointer MSB differs between laps. Empty requires all ADDR_SIZE+1 Gray bits equal. level_next = 2^ADDR_SIZE (full) is a legal value and is representable in r_level.
- r_q2_wptr may change by at most one Gray step per r_clk, as guaranteed by the synchronizer. Behaviour with multi-bit jumps is undefined except that r_level is still computed arithmetically.

Test Plan:
- Reset with r_q2_wptr=0: r_empty=1, r_almost_empty=1, r_ptr=0, r_addr=0, r_level=0. Pulsing r_inc for 5 cycles leaves all outputs unchanged.
- r_q2_wptr stepped 0->1->3->2 (Gray for 1,2,3), one per cycle: r_empty falls 1 cycle after 0x01 appears; r_level tracks 1,2,3; r_almost_empty=1 at level 1 and 0 at level 2 (ALMOST_EMPTY_LEVEL=1).
- With level 3, hold r_inc=1 for 4 cycles: r_addr 0->1->2->3; r_ptr 0x00->0x01->0x03->0x02; r_level 2,1,0; r_empty=1 after the third read. The fourth r_inc is ignored with r_addr held at 3.
- Full and wrap, ADDR_SIZE=4: advance r_q2_wptr to Gray(16)=0x18 with r_bin=0: r_level=16, r_empty=0. Read 16 words: r_ptr=0x18, r_empty=1, r_addr=0. Continue 16 more write/read pairs: r_ptr returns to 0x00, with no false empty mid-lap.
- Simultaneous events: at level 1, assert r_inc in the same cycle r_q2_wptr steps to the next code: r_empty stays 0 and r_level stays 1.
- Assert r_rst_n low asynchronously mid-burst at level 5: outputs go to reset values before the next r_clk edge. After release with r_q2_wptr=0, behaviour resumes from empty.
